// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - single-channel synchroniser, stable-time debouncer, edge pulses and sticky change flag
module debounce_chan #(
    parameter int   DebounceCycles = 50000,
    parameter int   CntWidth       = 16,
    parameter logic ResetValue     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    input  logic change_clr_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic change_o
);

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

    logic                sync1_q, sync2_q;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic                change_q, change_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            // New level held long enough: accept it and emit the matching pulse.
            level_d = ~level_q;
            cnt_d   = '0;
            rise_d  = ~level_q;
            fall_d  = level_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (rise_d || fall_d) begin
            change_d = 1'b1;
        end else if (change_clr_i) begin
            change_d = 1'b0;
        end else begin
            change_d = change_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q  <= ResetValue;
            sync2_q  <= ResetValue;
            cnt_q    <= '0;
            level_q  <= ResetValue;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            change_q <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign change_o = change_q;

endmodule

// File: rtl/board_gpio_debounce.sv
// rtl/board_gpio_debounce.sv - N-channel board pin conditioner feeding clean levels to gp_i
module board_gpio_debounce #(
    parameter int                     NumChannels    = 3,
    parameter int                     DebounceCycles = 50000,
    parameter logic [NumChannels-1:0] ResetValue     = '0
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_sys_ni,
    input  logic [NumChannels-1:0] raw_i,
    input  logic [NumChannels-1:0] change_clr_i,
    output logic [NumChannels-1:0] level_o,
    output logic [NumChannels-1:0] rise_o,
    output logic [NumChannels-1:0] fall_o,
    output logic [NumChannels-1:0] change_o
);

    // Counter only has to reach DebounceCycles-1; keep at least one bit for DebounceCycles=1.
    localparam int CntWidth = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;

    for (genvar i = 0; i < NumChannels; i++) begin : g_chan
        debounce_chan #(
            .DebounceCycles(DebounceCycles),
            .CntWidth      (CntWidth),
            .ResetValue    (ResetValue[i])
        ) u_chan (
            .clk_i       (clk_sys_i),
            .rst_ni      (rst_sys_ni),
            .raw_i       (raw_i[i]),
            .change_clr_i(change_clr_i[i]),
            .level_o     (level_o[i]),
            .rise_o      (rise_o[i]),
            .fall_o      (fall_o[i]),
            .change_o    (change_o[i])
        );
    end

endmodule

// File: tb/tb_board_gpio_debounce.sv
// tb/tb_board_gpio_debounce.sv - directed bench for board_gpio_debounce with a window-based reference model
module tb_board_gpio_debounce;

    localparam logic [2:0] RV = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] raw = 3'b000;
    logic [2:0] clr = 3'b000;

    logic [2:0] lvl4, rise4, fall4, chg4;
    logic [2:0] lvl1, rise1, fall1, chg1;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    board_gpio_debounce #(.NumChannels(3), .DebounceCycles(4), .ResetValue(RV)) u_dut4 (
        .clk_sys_i   (clk),
        .rst_sys_ni  (rst_n),
        .raw_i       (raw),
        .change_clr_i(clr),
        .level_o     (lvl4),
        .rise_o      (rise4),
        .fall_o      (fall4),
        .change_o    (chg4)
    );

    board_gpio_debounce #(.NumChannels(3), .DebounceCycles(1), .ResetValue(RV)) u_dut1 (
        .clk_sys_i   (clk),
        .rst_sys_ni  (rst_n),
        .raw_i       (raw),
        .change_clr_i(clr),
        .level_o     (lvl1),
        .rise_o      (rise1),
        .fall_o      (fall1),
        .change_o    (chg1)
    );

    initial forever #5 clk = ~clk;

    // Model: a level is accepted when the D most recent pin samples that have passed the
    // two synchroniser stages all disagree with the current level. h[m][j] = pin sampled j edges ago.
    int         dc [2] = '{4, 1};
    logic [2:0] h [2][0:5];
    logic [2:0] m_lvl [2];
    logic [2:0] m_rise [2];
    logic [2:0] m_fall [2];
    logic [2:0] m_chg [2];

    initial begin
        forever begin
            @(posedge clk);
            for (int m = 0; m < 2; m++) begin
                if (!rst_n) begin
                    for (int j = 0; j < 6; j++) h[m][j] = RV;
                    m_lvl[m]  = RV;
                    m_rise[m] = 3'b000;
                    m_fall[m] = 3'b000;
                    m_chg[m]  = 3'b000;
                end else begin
                    for (int j = 5; j > 0; j--) h[m][j] = h[m][j-1];
                    h[m][0]   = raw;
                    m_rise[m] = 3'b000;
                    m_fall[m] = 3'b000;
                    for (int c = 0; c < 3; c++) begin
                        bit all_diff;
                        all_diff = 1'b1;
                        for (int j = 2; j <= dc[m] + 1; j++)
                            if (h[m][j][c] == m_lvl[m][c]) all_diff = 1'b0;
                        if (all_diff) begin
                            if (m_lvl[m][c]) m_fall[m][c] = 1'b1;
                            else             m_rise[m][c] = 1'b1;
                            m_lvl[m][c] = ~m_lvl[m][c];
                        end
                        if (m_rise[m][c] || m_fall[m][c]) m_chg[m][c] = 1'b1;
                        else if (clr[c])                  m_chg[m][c] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("d4_level",  lvl4,  m_lvl[0]);
                chk("d4_rise",   rise4, m_rise[0]);
                chk("d4_fall",   fall4, m_fall[0]);
                chk("d4_change", chg4,  m_chg[0]);
                chk("d1_level",  lvl1,  m_lvl[1]);
                chk("d1_rise",   rise1, m_rise[1]);
                chk("d1_fall",   fall1, m_fall[1]);
                chk("d1_change", chg1,  m_chg[1]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with a pin already high on ch1.
        raw = 3'b010;
        tick(3);
        cmp_en = 1'b1;
        chk("rst_level",  lvl4, 3'b000);
        chk("rst_change", chg4, 3'b000);
        rst_n = 1'b1;
        tick(5);
        chk("t1_level_e5", lvl4, 3'b000);
        chk("t1_model_e5", m_lvl[0], 3'b000);
        tick(1);
        chk("t1_level_e6",  lvl4,     3'b010);
        chk("t1_rise_e6",   rise4,    3'b010);
        chk("t1_change_e6", chg4,     3'b010);
        chk("t1_model_e6",  m_rise[0], 3'b010);
        tick(1);
        chk("t1_rise_e7", rise4, 3'b000);

        // Glitch of 3 samples on ch0 is rejected.
        raw = 3'b011;
        tick(3);
        raw = 3'b010;
        tick(8);
        chk("t2_level",  lvl4, 3'b010);
        chk("t2_change", chg4, 3'b010);

        // Move to level 100, clear flags, then fall on ch2.
        raw = 3'b100;
        tick(8);
        chk("t3_level_pre", lvl4, 3'b100);
        clr = 3'b111;
        tick(1);
        clr = 3'b000;
        raw = 3'b000;
        tick(5);
        chk("t3_fall_e5", fall4, 3'b000);
        tick(1);
        chk("t3_fall_e6",   fall4,     3'b100);
        chk("t3_level_e6",  lvl4,      3'b000);
        chk("t3_change_e6", chg4,      3'b100);
        chk("t3_model_e6",  m_fall[0], 3'b100);
        tick(1);
        chk("t3_fall_e7", fall4, 3'b000);

        // Set beats clear on the same edge; clear alone works next cycle.
        raw = 3'b001;
        tick(8);
        chk("t4_change_set", chg4 & 3'b001, 3'b001);
        raw = 3'b000;
        tick(5);
        clr = 3'b001;
        tick(1);
        chk("t4_fall_e6",      fall4,         3'b001);
        chk("t4_change_kept",  chg4 & 3'b001, 3'b001);
        tick(1);
        chk("t4_change_clr",   chg4 & 3'b001, 3'b000);
        clr = 3'b000;

        // Reset mid-count discards progress.
        raw = 3'b010;
        tick(4);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("t5_level_e5", lvl4, 3'b000);
        tick(1);
        chk("t5_level_e6", lvl4,  3'b010);
        chk("t5_rise_e6",  rise4, 3'b010);
        tick(4);

        // DebounceCycles=1: simultaneous ch0/ch2 rise accepted on edge 3.
        raw = 3'b111;
        tick(2);
        chk("t6_level_e2", lvl1, 3'b010);
        tick(1);
        chk("t6_level_e3", lvl1,      3'b111);
        chk("t6_rise_e3",  rise1,     3'b101);
        chk("t6_model_e3", m_rise[1], 3'b101);
        tick(1);
        chk("t6_rise_e4", rise1, 3'b000);
        tick(8);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/board_gpio_debounce.md
# board_gpio_debounce

Parametrised N-channel input conditioner that sits between board switch/button pins and the `gp_i` input of `ibex_demo_system` in every board top-level. Each channel is synchronised, debounced with a programmable stable-time counter, and produces a clean level, single-cycle rise/fall event pulses, and a sticky change flag. It replaces the direct pin-to-`gp_i` wiring so software reads glitch-free switch state on any board.

## Interface
- `NumChannels`, default 3: number of independent input channels, ≥1.
- `DebounceCycles`, default 50000: clock cycles a new level must be held before it is accepted, ≥1 (1 ms at 50 MHz).
- `ResetValue`, default '0 (width `NumChannels`): per-channel level loaded at reset into the synchronisers and `level_o`.
- `clk_sys_i`  input  1  system clock; all flops on the rising edge.
- `rst_sys_ni`  input  1  reset, synchronous, active-low.
- `raw_i`  input  NumChannels  asynchronous board pins.
- `change_clr_i`  input  NumChannels  per-bit clear of `change_o`.
- `level_o`  output  NumChannels  debounced level.
- `rise_o`  output  NumChannels  one-cycle pulse when `level_o` bit goes 0→1.
- `fall_o`  output  NumChannels  one-cycle pulse when `level_o` bit goes 1→0.
- `change_o`  output  NumChannels  sticky flag, set by any rise/fall.

## Operation
- Per channel: 2-flop synchroniser `raw_i` → `sync1` → `sync2`.
- Counter `cnt`, width `CntWidth = $clog2(DebounceCycles)` with a minimum of 1.
- Each edge: if `sync2 == level_o`, then `cnt <= 0`. Otherwise, if `cnt == DebounceCycles-1`, then `level_o` flips, `cnt <= 0`, and the matching `rise_o` or `fall_o` bit is registered high for that cycle only. Otherwise `cnt <= cnt + 1`.
- A glitch shorter than `DebounceCycles` samples returns `cnt` to 0. There is no change and no pulse.
- `cnt` never exceeds `DebounceCycles-1`. No wrap-around is possible.
- `rise_o` and `fall_o` are never both high on one bit. A bit is high for exactly one cycle per accepted transition.
- `change_o[i]` is set on the edge where `rise_o[i]` or `fall_o[i]` is set. It is cleared by `change_clr_i[i]`. If set and clear occur in the same cycle, set wins.
- Reset values:
  - `sync1` and `sync2` take `ResetValue`.
  - `level_o` takes `ResetValue`.
  - `cnt` is 0.
  - `rise_o`, `fall_o` and `change_o` are 0.
- If `raw_i` differs from `ResetValue` at reset release, the channel debounces normally and emits one pulse.
- Reset asserted mid-count discards the count. No pulse is generated.

## Timing
- Raw-to-level latency: number the first edge that samples a new stable `raw_i` into `sync1` as edge 1. `level_o`, `rise_o`/`fall_o` and `change_o` update on edge `DebounceCycles+2`.
- Pulses are registered and coincident with the `level_o` change.
- `change_clr_i` takes effect on the next edge.
- No combinational path from any input to any output.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.

## Structure
- No shared package. `CntWidth` is a localparam. No enums: the per-channel state is the counter plus the level flop.
- One sub-module, `debounce_chan`: single channel with synchroniser, counter, level, pulse and sticky flag. It is instantiated `NumChannels` times by a generate loop in `board_gpio_debounce`.
- Board top-levels instantiate it on the switch pins and feed `level_o` to `gp_i`.

## Test plan
Bench parameters: `NumChannels=3`, `DebounceCycles=4`, `ResetValue=3'b000` unless stated.
- Reset with `raw_i=3'b010` held, then release → `level_o=000` until edge 6 after release. Then `level_o=010`, `rise_o=010` for one cycle, `change_o=010`.
- Start from steady 0 on ch0. Drive `raw_i[0]` high for 3 cycles, then low → `level_o`, `rise_o` and `change_o` stay 000 throughout.
- From `level_o=100`, drive `raw_i[2]` low and hold → `fall_o=100` for exactly one cycle on edge 6, `level_o=000`, `change_o[2]=1`.
- With `change_o[0]` already set, drive a new accepted ch0 transition and assert `change_clr_i=001` on that same edge → `change_o[0]` stays 1. Assert `change_clr_i=001` alone on the next cycle → `change_o[0]=0`.
- Toggle ch1, then assert reset after 2 counted cycles → after release `level_o=000` and `cnt=0`. With the input still held, the transition is accepted only on edge 6 after release.
- `DebounceCycles=1`, toggle ch0 and ch2 together → `level_o=101` on edge 3, with `rise_o=101` pulsed together.
